interval_sequencer: RTL and testbench

INTERVAL_SEQUENCER -- requirements
Module: interval_sequencer

---
 rtl/interval_seq_pkg.sv | 11 +
 rtl/seq_down_counter.sv | 26 ++
 rtl/interval_sequencer.sv | 138 +++++++++++++
 tb/tb_interval_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/interval_seq_pkg.sv
// Shared state encoding for the interval sequencer.
package interval_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable phase timer: counts down to zero while enabled, then holds at zero.
module seq_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/interval_sequencer.sv
// ON/OFF waveform sequencer repeating `reps` periods, then pulsing done.
// Optional pause input (freezes the running phase) is enabled by SEQ_PAUSE_EN.
module interval_sequencer
    import interval_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int REPW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
`ifdef SEQ_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [WIDTH-1:0] t_on,
    input  logic [WIDTH-1:0] t_off,
    input  logic [REPW-1:0]  reps,
    output logic             out_level,
    output logic             busy,
    output logic             done,
    output logic [REPW-1:0]  rep_cnt
);

    state_t           state, state_nx;
    logic [WIDTH-1:0] t_on_q, t_off_q;
    logic [REPW-1:0]  reps_q;
    logic [REPW:0]    rep_next;
    logic             last_rep;
    logic             launch, rep_inc, hold;
    logic             ctr_load, ctr_en, ctr_zero;
    logic [WIDTH-1:0] ctr_val;

`ifdef SEQ_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // A zero-length phase still occupies one cycle, so the timer gets max(t,1)-1.
    function automatic logic [WIDTH-1:0] phase_load(input logic [WIDTH-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    assign rep_next = {1'b0, rep_cnt} + (REPW+1)'(1);
    assign last_rep = (rep_next >= {1'b0, reps_q});

    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        rep_inc  = 1'b0;
        ctr_load = 1'b0;
        ctr_en   = 1'b0;
        ctr_val  = phase_load(t_on_q);
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    launch = 1'b1;
                    if (reps == '0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = ON;
                        ctr_load = 1'b1;
                        ctr_val  = phase_load(t_on);
                    end
                end
            end
            ON: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (!hold) begin
                    ctr_en = 1'b1;
                    if (ctr_zero) begin
                        state_nx = OFF;
                        ctr_load = 1'b1;
                        ctr_val  = phase_load(t_off_q);
                    end
                end
            end
            OFF: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (!hold) begin
                    ctr_en = 1'b1;
                    if (ctr_zero) begin
                        rep_inc = 1'b1;
                        if (last_rep) begin
                            state_nx = DONE;
                        end else begin
                            state_nx = ON;
                            ctr_load = 1'b1;
                        end
                    end
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Launch parameters are held here so input changes mid-sequence are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            t_on_q  <= '0;
            t_off_q <= '0;
            reps_q  <= '0;
            rep_cnt <= '0;
        end else if (launch) begin
            t_on_q  <= t_on;
            t_off_q <= t_off;
            reps_q  <= reps;
            rep_cnt <= '0;
        end else if (rep_inc) begin
            rep_cnt <= rep_next[REPW-1:0];
        end
    end

    seq_down_counter #(.WIDTH(WIDTH)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .load_val (ctr_val),
        .en       (ctr_en),
        .zero     (ctr_zero)
    );

    assign out_level = (state == ON);
    assign busy      = (state == ON) || (state == OFF);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_interval_sequencer.sv
// Self-checking bench: per-cycle expected waveform built from the period rules.
module tb_interval_sequencer;

    localparam int WIDTH = 8;
    localparam int REPW  = 4;

    logic             clk = 1'b0;
    logic             reset, start, abort;
    logic [WIDTH-1:0] t_on, t_off;
    logic [REPW-1:0]  reps;
    logic             out_level, busy, done;
    logic [REPW-1:0]  rep_cnt;
`ifdef SEQ_PAUSE_EN
    logic             pause;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit out;
        bit bsy;
        bit dn;
        int rep;
    } exp_t;

    always #5 clk = ~clk;

    interval_sequencer #(.WIDTH(WIDTH), .REPW(REPW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
`ifdef SEQ_PAUSE_EN
        .pause     (pause),
`endif
        .t_on      (t_on),
        .t_off     (t_off),
        .reps      (reps),
        .out_level (out_level),
        .busy      (busy),
        .done      (done),
        .rep_cnt   (rep_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_out(input exp_t e, input string name, input int c);
        chk($sformatf("%s c%0d out_level", name, c), 32'(out_level), int'(e.out));
        chk($sformatf("%s c%0d busy", name, c), 32'(busy), int'(e.bsy));
        chk($sformatf("%s c%0d done", name, c), 32'(done), int'(e.dn));
        chk($sformatf("%s c%0d rep_cnt", name, c), 32'(rep_cnt), e.rep);
    endtask

    // Launch one sequence and follow it cycle by cycle. The expected trace is
    // a list of phases; abort truncates it, pause repeats the current cycle.
    task automatic run_seq(input int tn, input int tf, input int rp, input int abort_at,
                           input bit rnd, input int pf, input int pl, input string name);
        exp_t q[$];
        exp_t e;
        int   c;
        for (int r = 0; r < rp; r++) begin
            repeat ((tn < 1) ? 1 : tn) q.push_back('{1'b1, 1'b1, 1'b0, r});
            repeat ((tf < 1) ? 1 : tf) q.push_back('{1'b0, 1'b1, 1'b0, r});
        end
        q.push_back('{1'b0, 1'b0, 1'b1, rp});
        q.push_back('{1'b0, 1'b0, 1'b0, rp});

        start = 1'b1;
        abort = 1'b0;
        t_on  = WIDTH'(tn);
        t_off = WIDTH'(tf);
        reps  = REPW'(rp);
`ifdef SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        @(posedge clk); #1;
        c = 1;
        while (q.size() > 0) begin
            e = q.pop_front();
            // Garbage on the parameter inputs and start must not disturb a running sequence.
            start = (e.bsy || e.dn) ? 1'($urandom_range(0, 1)) : 1'b0;
            t_on  = WIDTH'($urandom);
            t_off = WIDTH'($urandom);
            reps  = REPW'($urandom);
            abort = 1'b0;
            if (e.bsy && (c == abort_at || (rnd && $urandom_range(0, 29) == 0))) begin
                abort = 1'b1;
                q.delete();
                q.push_back('{1'b0, 1'b0, 1'b0, e.rep});
            end else if (!e.bsy && rnd) begin
                abort = 1'($urandom_range(0, 1));
            end
`ifdef SEQ_PAUSE_EN
            pause = 1'b0;
            if (!abort) begin
                pause = (c >= pf && c < pf + pl) || (rnd && $urandom_range(0, 3) == 0);
                if (pause && e.bsy) q.push_front(e);
            end else if (rnd) begin
                pause = 1'($urandom_range(0, 1));
            end
`endif
            @(negedge clk);
            check_out(e, name, c);
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        abort = 1'b0;
`ifdef SEQ_PAUSE_EN
        pause = 1'b0;
`endif
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        t_on  = '0;
        t_off = '0;
        reps  = '0;
`ifdef SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_out('{1'b0, 1'b0, 1'b0, 0}, "reset", 0);
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;

        run_seq(3, 2, 2, -1, 1'b0, -1, 0, "basic");
        run_seq(4, 1, 0, -1, 1'b0, -1, 0, "reps0");
        run_seq(0, 0, 3, -1, 1'b0, -1, 0, "zero_len");
        run_seq(4, 2, 2, 2, 1'b0, -1, 0, "abort_on");
        run_seq(5, 3, 1, 1, 1'b0, -1, 0, "abort_first");

        // Reset in the middle of OFF, with start held high to test priority.
        start = 1'b1;
        t_on  = 8'd2;
        t_off = 8'd4;
        reps  = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_out('{1'b0, 1'b1, 1'b0, 0}, "pre_reset", 4);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_out('{1'b0, 1'b0, 1'b0, 0}, "mid_off_reset", 5);
        @(posedge clk); #1;
        run_seq(2, 3, 2, -1, 1'b0, -1, 0, "after_reset");

`ifdef SEQ_PAUSE_EN
        run_seq(3, 1, 1, -1, 1'b0, 2, 4, "pause_on");
`endif

        for (int i = 0; i < 25; i++)
            run_seq(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 4)), -1, 1'b1, -1, 0, $sformatf("rand%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
